gradient_descent_poly: RTL and testbench
========================================

Name: gradient_descent_poly

Overview:
- Iterative fixed-point gradient-descent engine for the quadratic f(x) = a·x² + b·x.
- On a start pulse it latches x, alpha, a and b, then applies x ← x − alpha·(2·a·x + b) exactly MAX_ITER times.
- It presents the final x and raises ready.
- It is a standalone compute block driven by a controller through a start/ready handshake.

Parameters:
- N, 16: total word width of all data ports (signed two's complement).
- M, 8: fractional bits (Q(N−M).M format); 1.0 = 2^M.
- MAX_ITER, 10: number of update iterations per job (≥0).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset. Asynchronous and active-high.
- start  in  1  one-cycle request; inputs are sampled on the same edge.
- x  in  N  initial point, signed Q.M.
- alpha  in  N  learning rate, signed Q.M.
- a  in  N  quadratic coefficient, signed Q.M.
- b  in  N  linear coefficient, signed Q.M.
- x_next  out  N  result after MAX_ITER iterations, signed Q.M.
- ready  out  1  high when x_next holds a valid completed result.

Behaviour:
- Reset (async): state=IDLE, ready=0, x_next=0, iteration counter=0, all internal registers=0.
- FSM states:
  - IDLE: wait for start.
  - GRAD: compute and register gradient g.
  - UPD: compute new x, increment counter.
  - DONE: ready=1, x_next held.
- Transitions:
  - IDLE/DONE + start → latch inputs, ready←0. Go to GRAD, or straight to DONE when MAX_ITER=0 (x_next=x).
  - GRAD → UPD.
  - UPD → GRAD while counter < MAX_ITER, else DONE.
- Latency: start sampled at edge k → ready=1 after edge k + 2·MAX_ITER + 1 (21 cycles at default).
- x_next stays stable and ready stays high in DONE until the next start.
- start while GRAD/UPD is ignored; the running job is unaffected.
- Reset mid-job aborts immediately to reset values.
- Arithmetic per iteration:
  - p = a·x, a 2N-bit signed product.
  - g = ((2·p) >> M, rounded) + b. Keep g at 2N+2 bits with no saturation.
  - s = (alpha·g) >> M, rounded, held at full width.
  - x_new = sat_N(x − s).
- Rounding: round-half-up. Add 2^(M−1) before the arithmetic right shift.
- Saturation only on x_new: clamp to [−2^(N−1)+1, 2^(N−1)−1] (symmetric; −32768 never produced).
- The updated x is held internally at N bits; x_next is updated from it on entry to DONE.
- Accuracy target: within 0.05 (real) of the exact real-arithmetic recurrence for non-saturating cases.

Decomposition:
- Shared package gd_pkg:
  - constants N, M, ONE=2^M, SAT_MAX, SAT_MIN;
  - state enum {IDLE, GRAD, UPD, DONE}.
- One natural sub-module: fxp_mul_round, a signed multiply with rounded arithmetic right shift by M. It is instantiated twice, for a·x and alpha·g, with a width parameter.
- Saturation is done inline in the top module.

Test Plan:
- All zeros (x=0, alpha=0, a=0, b=0) → ready after 21 cycles, x_next=0.
- x=256, alpha=256, a=256, b=−256 → iterates oscillate 0,1,0,…; after 10 iterations x_next=256. Mirror case x=−256, b=+256 → x_next=−256.
- x=256, alpha=256, a=0, b=256 → x drops by 1.0 per iteration; x_next=−2304 (−9.0).
- x=256, alpha=1, a=256, b=0 → x_next=236, within 0.05 of real 0.9246.
- Saturation:
  - x=−32768, alpha=256, a=256, b=0 → first iteration clamps to +32767, then alternates; final x_next=−32767.
  - x=32767, same alpha/a/b → x_next=32767.
- Control:
  - Reset asserted mid-job → ready=0 and x_next=0 immediately.
  - start pulsed during a job → ignored; original job's result and latency unchanged.
  - Back-to-back jobs → second start from DONE drops ready on the next edge.

Source files
------------

// File: rtl/gd_pkg.sv
// Shared constants and FSM state type for the quadratic gradient-descent engine.
package gd_pkg;
  localparam int N       = 16;
  localparam int M       = 8;
  localparam int ONE     = 1 << M;
  localparam int SAT_MAX = (1 << (N - 1)) - 1;
  localparam int SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {IDLE, GRAD, UPD, DONE} state_e;
endpackage

// File: rtl/fxp_mul_round.sv
// Signed full-width multiply followed by a round-half-up arithmetic shift right by M.
module fxp_mul_round #(
  parameter int WA = 16,
  parameter int WB = 16,
  parameter int M  = 8
) (
  input  logic signed [WA-1:0]    a_i,
  input  logic signed [WB-1:0]    b_i,
  output logic signed [WA+WB-1:0] y_o
);
  localparam int WP = WA + WB;
  localparam logic signed [WP-1:0] RND = WP'(2 ** (M - 1));

  // The product of two signed operands never reaches the top bit, so adding RND cannot wrap.
  logic signed [WP-1:0] prod;

  assign prod = a_i * b_i;
  assign y_o  = (prod + RND) >>> M;
endmodule

// File: rtl/gradient_descent_poly.sv
// Iterative gradient descent on f(x) = a*x^2 + b*x: x <- sat(x - alpha*(2*a*x + b)), MAX_ITER times.
// IDLE: wait for start | GRAD: register gradient | UPD: update x, count | DONE: result valid
module gradient_descent_poly #(
  parameter int N        = gd_pkg::N,
  parameter int M        = gd_pkg::M,
  parameter int MAX_ITER = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] x,
  input  logic signed [N-1:0] alpha,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] x_next,
  output logic                ready
);
  import gd_pkg::*;

  localparam int PW = 2 * N + 1;
  localparam int GW = 2 * N + 2;
  localparam int SW = 3 * N + 2;
  localparam int DW = 3 * N + 3;
  localparam int CW = $clog2(MAX_ITER + 2);
  localparam logic signed [DW-1:0] HI = DW'((2 ** (N - 1)) - 1);
  localparam logic signed [DW-1:0] LO = -HI;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic signed [N-1:0]  x_q, alpha_q, a_q, b_q;
  logic signed [GW-1:0] g_q;

  logic signed [PW-1:0] p2_rnd;
  logic signed [GW-1:0] g_d;
  logic signed [SW-1:0] s;
  logic signed [DW-1:0] diff;
  logic signed [N-1:0]  x_d;
  logic [CW-1:0]        cnt_d;

  // Feeding 2*x rounds the doubled product once instead of doubling a rounded one.
  fxp_mul_round #(.WA(N), .WB(N + 1), .M(M)) u_mul_ax (
    .a_i(a_q),
    .b_i({x_q, 1'b0}),
    .y_o(p2_rnd)
  );

  assign g_d = GW'(p2_rnd) + GW'(b_q);

  fxp_mul_round #(.WA(N), .WB(GW), .M(M)) u_mul_ag (
    .a_i(alpha_q),
    .b_i(g_q),
    .y_o(s)
  );

  assign diff  = DW'(x_q) - DW'(s);
  assign cnt_d = cnt_q + CW'(1);

  always_comb begin
    x_d = diff[N-1:0];
    if (diff > HI)      x_d = HI[N-1:0];
    else if (diff < LO) x_d = LO[N-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      alpha_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      x_next  <= '0;
      ready   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            x_q     <= x;
            alpha_q <= alpha;
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= '0;
            ready   <= 1'b0;
            if (MAX_ITER == 0) begin
              x_next  <= x;
              state_q <= DONE;
            end else begin
              state_q <= GRAD;
            end
          end else if (state_q == DONE) begin
            ready <= 1'b1;
          end
        end
        GRAD: begin
          g_q     <= g_d;
          state_q <= UPD;
        end
        UPD: begin
          x_q   <= x_d;
          cnt_q <= cnt_d;
          if (cnt_d < CW'(MAX_ITER)) begin
            state_q <= GRAD;
          end else begin
            x_next  <= x_d;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gradient_descent_poly.sv
// Scoreboard bench for gradient_descent_poly against a plain-arithmetic reference of the recurrence.
module tb_gradient_descent_poly;
  localparam int N        = 16;
  localparam int M        = 8;
  localparam int MAX_ITER = 10;
  localparam int LAT      = 2 * MAX_ITER + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic signed [N-1:0] x, alpha, a, b;
  logic signed [N-1:0] x_next;
  logic                ready;

  typedef struct {
    logic signed [N-1:0] xe;
    int                  start_cyc;
  } exp_t;

  exp_t                sb[$];
  int                  cyc = 0;
  int                  n_checks = 0;
  int                  n_pass = 0;
  logic signed [N-1:0] last_exp;

  gradient_descent_poly #(.N(N), .M(M), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .x(x),
    .alpha(alpha),
    .a(a),
    .b(b),
    .x_next(x_next),
    .ready(ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Real-valued recurrence on integers scaled by 2^M, rounding half up, clamping symmetrically.
  function automatic logic signed [N-1:0] ref_model(input logic signed [N-1:0] x0,
                                                     input logic signed [N-1:0] al,
                                                     input logic signed [N-1:0] a0,
                                                     input logic signed [N-1:0] b0);
    longint xv, g, s, half, lim;
    logic signed [N-1:0] r;
    half = longint'(1) << (M - 1);
    lim  = (longint'(1) << (N - 1)) - 1;
    xv   = longint'(x0);
    for (int i = 0; i < MAX_ITER; i++) begin
      g  = ((2 * longint'(a0) * xv + half) >>> M) + longint'(b0);
      s  = (longint'(al) * g + half) >>> M;
      xv = xv - s;
      if (xv > lim) xv = lim;
      if (xv < -lim) xv = -lim;
    end
    r = xv[N-1:0];
    return r;
  endfunction

  task automatic run_job(input logic signed [N-1:0] xi, input logic signed [N-1:0] ali,
                         input logic signed [N-1:0] ai, input logic signed [N-1:0] bi,
                         input bit track);
    exp_t e;
    bit   was_done;
    @(negedge clk);
    was_done = ready;
    x = xi; alpha = ali; a = ai; b = bi;
    start = 1'b1;
    if (track) begin
      e.xe        = ref_model(xi, ali, ai, bi);
      e.start_cyc = cyc + 1;
      last_exp    = e.xe;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (was_done) check("ready_drop_on_restart", ready, 0);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check({name, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic check_hold();
    repeat (3) @(negedge clk);
    check("hold_ready", ready, 1);
    check("hold_x_next", x_next, last_exp);
  endtask

  initial begin : monitor
    logic rp;
    exp_t e;
    rp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rp = 1'b0;
      end else begin
        if (ready && !rp) begin
          if (sb.size() == 0) begin
            check("unexpected_ready", 1, 0);
          end else begin
            e = sb.pop_front();
            check("x_next", x_next, e.xe);
            check("latency", cyc - e.start_cyc, LAT);
          end
        end
        rp = ready;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d of %0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : driver
    logic signed [N-1:0] dx[7]  = '{16'sd0, 16'sd256, -16'sd256, 16'sd256, 16'sd256, -16'sd32768, 16'sd32767};
    logic signed [N-1:0] dal[7] = '{16'sd0, 16'sd256, 16'sd256, 16'sd256, 16'sd1, 16'sd256, 16'sd256};
    logic signed [N-1:0] da[7]  = '{16'sd0, 16'sd256, 16'sd256, 16'sd0, 16'sd256, 16'sd256, 16'sd256};
    logic signed [N-1:0] db[7]  = '{16'sd0, -16'sd256, 16'sd256, 16'sd256, 16'sd0, 16'sd0, 16'sd0};
    rst = 1'b1; start = 1'b0; x = '0; alpha = '0; a = '0; b = '0;
    last_exp = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", ready, 0);
    check("reset_x_next", x_next, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_job(dx[i], dal[i], da[i], db[i], 1'b1);
      wait_done("directed");
      check_hold();
    end

    // Reset mid-job with a nonzero held result.
    run_job(16'sd1000, 16'sd64, 16'sd128, 16'sd32, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midjob_reset_ready", ready, 0);
    check("midjob_reset_x_next", x_next, 0);
    @(negedge clk);
    rst = 1'b0;

    // A second start inside a running job must be ignored.
    run_job(16'sd1280, 16'sd32, 16'sd200, -16'sd300, 1'b1);
    repeat (4) @(negedge clk);
    run_job(-16'sd5000, 16'sd100, -16'sd90, 16'sd700, 1'b0);
    repeat (3) @(negedge clk);
    run_job(16'sd77, 16'sd255, 16'sd13, 16'sd999, 1'b0);
    wait_done("ignored_start");
    check_hold();

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0)
        run_job(N'(int'($urandom_range(0, 4095)) - 2048), N'(int'($urandom_range(0, 127))),
                N'(int'($urandom_range(0, 1023)) - 512), N'(int'($urandom_range(0, 2047)) - 1024), 1'b1);
      else
        run_job(N'($urandom), N'($urandom), N'($urandom), N'($urandom), 1'b1);
      wait_done("random");
    end
    check_hold();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
